interleaver_wimax_phy: RTL and testbench

Block interleaver for the WiMAX PHY chain, QPSK rate-1/2 (Ncbps = 192, Ncpc = 2, d = 16). It sits directly downstream of the FEC encoder and upstream of the modulator. It takes the encoder's serial coded bit stream on the 100 MHz domain and permutes each 192-bit block. It emits the block serially in interleaved order through a ping-pong buffer, so one block can be written while the previous block drains.

---
 rtl/interleaver_wimax_phy.sv | 99 +++++++++
 tb/tb_interleaver_wimax_phy.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/interleaver_wimax_phy.sv
// WiMAX QPSK rate-1/2 block interleaver (Ncbps=192, d=16) with ping-pong banks.
// One bank fills in permuted order while the other drains sequentially.
module interleaver_wimax_phy #(
  parameter int BLOCK_SIZE = 192,
  parameter int ROWS       = 16,
  parameter int COLS       = BLOCK_SIZE / ROWS
) (
  input  logic clk_100,
  input  logic reset,
  input  logic fec_encoder_valid,
  input  logic data_in,
  input  logic modulator_ready,
  output logic ready_out,
  output logic valid_out,
  output logic data_out
);

  localparam int AW = $clog2(BLOCK_SIZE);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(BLOCK_SIZE - 1);

  logic [BLOCK_SIZE-1:0] bank0;
  logic [BLOCK_SIZE-1:0] bank1;
  logic [1:0]            full;
  logic                  wsel;
  logic                  rsel;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic [AW-1:0]         rd_addr;
  logic [AW-1:0]         wr_addr;
  logic                  accept;
  logic                  transfer;
  logic                  rd_bit;

  assign ready_out = !full[wsel];
  assign valid_out = full[rsel];
  assign accept    = fec_encoder_valid && ready_out;
  assign transfer  = valid_out && modulator_ready;

  // Input bit k = ROWS*col + row lands at COLS*row + col; the second
  // permutation is identity for two coded bits per carrier.
  assign wr_addr = AW'(COLS) * AW'(row) + AW'(col);

  assign rd_bit   = rsel ? bank1[rd_addr] : bank0[rd_addr];
  assign data_out = valid_out & rd_bit;

  // Bank contents are deliberately left out of reset.
  always_ff @(posedge clk_100) begin
    if (accept) begin
      if (wsel) begin
        bank1[wr_addr] <= data_in;
      end else begin
        bank0[wr_addr] <= data_in;
      end
    end
  end

  // Write and read completions touch different full bits, since a write
  // never targets a full bank while a read only drains a full one.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      full    <= 2'b00;
      wsel    <= 1'b0;
      rsel    <= 1'b0;
      row     <= '0;
      col     <= '0;
      rd_addr <= '0;
    end else begin
      if (accept) begin
        if (row == ROW_LAST) begin
          row <= '0;
          if (col == COL_LAST) begin
            col        <= '0;
            full[wsel] <= 1'b1;
            wsel       <= !wsel;
          end else begin
            col <= col + CW'(1);
          end
        end else begin
          row <= row + RW'(1);
        end
      end
      if (transfer) begin
        if (rd_addr == ADDR_LAST) begin
          rd_addr    <= '0;
          full[rsel] <= 1'b0;
          rsel       <= !rsel;
        end else begin
          rd_addr <= rd_addr + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_interleaver_wimax_phy.sv
// Directed self-checking bench for interleaver_wimax_phy.
// Expected output blocks come from the net mapping m -> k = 16*(m mod 12) + m/12.
module tb_interleaver_wimax_phy;

  localparam int N = 192;

  logic clk_100           = 1'b0;
  logic reset             = 1'b1;
  logic fec_encoder_valid = 1'b0;
  logic data_in           = 1'b0;
  logic modulator_ready   = 1'b0;
  logic ready_out;
  logic valid_out;
  logic data_out;

  int   checks   = 0;
  int   failures = 0;
  logic tx_q[$];
  logic rx_q[$];
  bit   ready_dropped;
  bit   valid_gap;

  interleaver_wimax_phy dut (
    .clk_100           (clk_100),
    .reset             (reset),
    .fec_encoder_valid (fec_encoder_valid),
    .data_in           (data_in),
    .modulator_ready   (modulator_ready),
    .ready_out         (ready_out),
    .valid_out         (valid_out),
    .data_out          (data_out)
  );

  always #5 clk_100 = ~clk_100;

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] interleave(input logic [N-1:0] blk);
    logic [N-1:0] v;
    for (int m = 0; m < N; m++) v[m] = blk[16 * (m % 12) + m / 12];
    return v;
  endfunction

  function automatic logic [N-1:0] rand_block();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic load_block(input logic [N-1:0] blk);
    for (int k = 0; k < N; k++) tx_q.push_back(blk[k]);
  endtask

  task automatic take_block(output logic [N-1:0] blk);
    blk = 'x;
    for (int m = 0; m < N; m++) begin
      if (rx_q.size() > 0) blk[m] = rx_q.pop_front();
    end
  endtask

  // Streams tx_q into the DUT and gathers rx_target output bits, bounded by a cycle budget.
  task automatic apply_stimulus(input bit gaps, input bit mready, input int rx_target, input string tag);
    int cyc = 0;
    bit seen_valid = 0;
    ready_dropped = 0;
    valid_gap     = 0;
    while (rx_q.size() < rx_target && cyc < 5000) begin
      fec_encoder_valid = (tx_q.size() > 0) && (!gaps || ($urandom_range(0, 1) == 1));
      data_in           = (tx_q.size() > 0) ? tx_q[0] : 1'b0;
      modulator_ready   = mready;
      if (tx_q.size() > 0 && !ready_out) ready_dropped = 1;
      if (seen_valid && !valid_out) valid_gap = 1;
      if (valid_out) seen_valid = 1;
      if (fec_encoder_valid && ready_out) void'(tx_q.pop_front());
      if (valid_out && modulator_ready) rx_q.push_back(data_out);
      tick();
      cyc++;
    end
    fec_encoder_valid = 1'b0;
    modulator_ready   = 1'b0;
    check_output({tag, "_count"}, N'(rx_q.size()), N'(rx_target));
  endtask

  initial begin
    logic [N-1:0] blk;
    logic [N-1:0] got;
    logic [N-1:0] ramp;
    logic [N-1:0] blks[4];
    int   probe_k[3] = '{1, 16, 191};
    int   probe_m[3] = '{12, 1, 191};
    bit   flag;
    bit   v_before;
    logic d0;

    $display("[TB] reset state");
    reset = 1'b1;
    tick();
    tick();
    check_output("reset_ready", N'(ready_out), N'(1));
    check_output("reset_valid", N'(valid_out), N'(0));
    check_output("reset_data", N'(data_out), N'(0));
    reset = 1'b0;

    $display("[TB] single-one probes");
    for (int i = 0; i < 3; i++) begin
      blk = '0;
      blk[probe_k[i]] = 1'b1;
      load_block(blk);
      apply_stimulus(1'b0, 1'b1, N, "probe");
      take_block(got);
      check_output($sformatf("probe_k%0d", probe_k[i]), got, N'(1) << probe_m[i]);
    end

    $display("[TB] ramp pattern and latency");
    flag = 0;
    v_before = 1'b1;
    for (int k = 0; k < N; k++) begin
      fec_encoder_valid = 1'b1;
      data_in           = (k % 3 == 0);
      ramp[k]           = (k % 3 == 0);
      modulator_ready   = 1'b1;
      if (!ready_out) flag = 1;
      if (k == N - 1) v_before = valid_out;
      tick();
    end
    fec_encoder_valid = 1'b0;
    check_output("ramp_ready_high", N'(flag), N'(0));
    check_output("ramp_valid_at_last_accept", N'(v_before), N'(0));
    check_output("ramp_valid_after", N'(valid_out), N'(1));
    check_output("ramp_first_bit", N'(data_out), N'(1));
    apply_stimulus(1'b0, 1'b1, N, "ramp");
    take_block(got);
    check_output("ramp_first12", N'(got[11:0]), N'(12'h249));
    check_output("ramp_block", got, interleave(ramp));

    $display("[TB] back-to-back blocks");
    for (int i = 0; i < 4; i++) begin
      blks[i] = rand_block();
      load_block(blks[i]);
    end
    apply_stimulus(1'b0, 1'b1, 4 * N, "b2b");
    check_output("b2b_ready_drop", N'(ready_dropped), N'(0));
    check_output("b2b_valid_gap", N'(valid_gap), N'(0));
    for (int i = 0; i < 4; i++) begin
      take_block(got);
      check_output($sformatf("b2b_block%0d", i), got, interleave(blks[i]));
    end

    $display("[TB] output backpressure");
    blks[0] = rand_block();
    blks[1] = rand_block();
    flag = 0;
    for (int i = 0; i < 2 * N; i++) begin
      fec_encoder_valid = 1'b1;
      data_in           = (i < N) ? blks[0][i] : blks[1][i-N];
      modulator_ready   = 1'b0;
      if (!ready_out) flag = 1;
      tick();
    end
    check_output("bp_ready_while_filling", N'(flag), N'(0));
    check_output("bp_ready_low", N'(ready_out), N'(0));
    check_output("bp_valid_high", N'(valid_out), N'(1));
    d0 = data_out;
    check_output("bp_first_bit", N'(d0), N'(blks[0][0]));
    flag = 0;
    for (int i = 0; i < 10; i++) begin
      fec_encoder_valid = 1'b1;
      data_in           = ~d0;
      tick();
      if (data_out !== d0 || valid_out !== 1'b1 || ready_out !== 1'b0) flag = 1;
    end
    fec_encoder_valid = 1'b0;
    check_output("bp_stable", N'(flag), N'(0));
    apply_stimulus(1'b0, 1'b1, 2 * N, "bp_drain");
    for (int i = 0; i < 2; i++) begin
      take_block(got);
      check_output($sformatf("bp_block%0d", i), got, interleave(blks[i]));
    end
    check_output("bp_idle_valid", N'(valid_out), N'(0));
    check_output("bp_idle_ready", N'(ready_out), N'(1));

    $display("[TB] input gaps");
    blk = rand_block();
    load_block(blk);
    apply_stimulus(1'b1, 1'b1, N, "gaps");
    take_block(got);
    check_output("gaps_block", got, interleave(blk));

    $display("[TB] reset mid-operation");
    blks[0] = rand_block();
    blks[1] = rand_block();
    for (int i = 0; i < N + 100; i++) begin
      fec_encoder_valid = 1'b1;
      data_in           = (i < N) ? blks[0][i] : blks[1][i-N];
      modulator_ready   = 1'b1;
      tick();
    end
    fec_encoder_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_output("midreset_valid", N'(valid_out), N'(0));
    check_output("midreset_ready", N'(ready_out), N'(1));
    check_output("midreset_data", N'(data_out), N'(0));
    reset = 1'b0;
    blk = rand_block();
    load_block(blk);
    apply_stimulus(1'b0, 1'b1, N, "post_reset");
    take_block(got);
    check_output("post_reset_block", got, interleave(blk));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
